// File: rtl/ham_decode_sched.sv
// Round-robin scheduler sharing one Hamming(7,4) decoder among NREQ requesters.
// Optional build macro ERR_INJECT_EN adds inj_en/inj_mask to corrupt latched codewords for self-test.
//
// state     | meaning
// ST_IDLE   | waiting for a request; grants at most one per cycle
// ST_DECODE | code_q presented to the decoder, response registers loaded
// ST_RESP   | rsp_valid held until the consumer takes it

module ham_decoder (
    input  logic [6:0] code,
    output logic [2:0] syndrome
);
    assign syndrome[0] = code[0] ^ code[2] ^ code[4] ^ code[6];
    assign syndrome[1] = code[1] ^ code[2] ^ code[5] ^ code[6];
    assign syndrome[2] = code[3] ^ code[4] ^ code[5] ^ code[6];
endmodule

module ham_decode_sched #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [7*NREQ-1:0]    req_code,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2:0]           rsp_id,
    output logic [3:0]           rsp_data,
    output logic                 rsp_err,
    output logic [2:0]           rsp_pos,
    input  logic                 clr_count,
    output logic [CNT_W-1:0]     err_count
`ifdef ERR_INJECT_EN
    ,
    input  logic                 inj_en,
    input  logic [6:0]           inj_mask
`endif
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [6:0]         code_q, code_d;
    logic [2:0]         id_q, id_d;
    logic [2:0]         rsp_id_q, rsp_id_d;
    logic [3:0]         rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic [2:0]         rsp_pos_q, rsp_pos_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    logic               grant_found;
    logic [2:0]         grant_idx;
    logic [PTR_W-1:0]   grant_next;
    logic [6:0]         grant_code;
    logic [6:0]         inj_word;
    logic [2:0]         syndrome;
    logic [6:0]         flip;
    logic [6:0]         corrected;

`ifdef ERR_INJECT_EN
    assign inj_word = inj_en ? inj_mask : 7'd0;
`else
    assign inj_word = 7'd0;
`endif

    ham_decoder u_dec (
        .code     (code_q),
        .syndrome (syndrome)
    );

    // Circular search starting at rr_ptr; first hit wins.
    always_comb begin : grant_sel
        int cand;
        logic [NREQ-1:0] vshift;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_next  = '0;
        grant_code  = '0;
        cand        = 0;
        vshift      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand   = (int'(rr_ptr_q) + i) % NREQ;
            vshift = req_valid >> cand;
            if (!grant_found && vshift[0]) begin
                grant_found = 1'b1;
                grant_idx   = 3'(cand);
                grant_next  = PTR_W'((cand + 1) % NREQ);
                grant_code  = 7'(req_code >> (7 * cand));
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        code_d      = code_q;
        id_d        = id_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_pos_d   = rsp_pos_q;
        err_count_d = err_count_q;
        req_ready   = '0;
        flip        = '0;
        if (syndrome != 3'd0) begin
            flip = 7'd1 << (syndrome - 3'd1);
        end
        corrected = code_q ^ flip;

        case (state_q)
            ST_IDLE: begin
                // Gated by rst so a requester never sees an accept that reset discards.
                if (grant_found && !rst) begin
                    req_ready = NREQ'(1) << grant_idx;
                    code_d    = grant_code ^ inj_word;
                    id_d      = grant_idx;
                    rr_ptr_d  = grant_next;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                rsp_pos_d  = syndrome;
                rsp_err_d  = (syndrome != 3'd0);
                rsp_data_d = {corrected[6], corrected[5], corrected[4], corrected[2]};
                rsp_id_d   = id_q;
                if ((syndrome != 3'd0) && !(&err_count_q)) begin
                    err_count_d = err_count_q + CNT_W'(1);
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (clr_count) begin
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            code_q      <= '0;
            id_q        <= '0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_pos_q   <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            code_q      <= code_d;
            id_q        <= id_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_pos_q   <= rsp_pos_d;
            err_count_q <= err_count_d;
        end
    end

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_pos   = rsp_pos_q;
    assign err_count = err_count_q;

endmodule

// File: doc/ham_decode_sched.md
Name: ham_decode_sched

Overview:
Round-robin scheduler that shares one Hamming(7,4) decoder (instance of ham_decoder) among NREQ requesters. It grants one requester, latches its codeword and registers the decode result. It then applies single-bit correction and returns data, error flag and error position over a valid/ready response channel. It also keeps a saturating count of corrected errors for status readout.

Parameters:
NREQ, 4, number of requesters (2..8)
CNT_W, 16, width of corrected-error counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NREQ  per-requester request
req_code  in  7*NREQ  codeword of requester i at bits [7i+6:7i]
req_ready  out  NREQ  one-hot accept pulse
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  3  index of requester being answered
rsp_data  out  4  corrected data {d3,d2,d1,d0}
rsp_err  out  1  nonzero syndrome detected
rsp_pos  out  3  syndrome / error position (0 = none)
clr_count  in  1  clear err_count
err_count  out  CNT_W  saturating count of responses with rsp_err=1

Behaviour:
- Codeword convention: bit k holds Hamming position k+1.
  - Parity bits at positions 1, 2, 4.
  - d0..d3 at positions 3, 5, 6, 7, i.e. bits 2, 4, 5, 6.
  - Syndrome s0/s1/s2 = XOR over positions with bit0/bit1/bit2 set.
- Reset: FSM=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, rsp_pos=0, err_count=0.
- FSM IDLE:
  - If any req_valid, grant the first asserted index at or after rr_ptr (circular).
  - Pulse req_ready[g] for that one cycle.
  - Latch req_code slice g into code_q and g into id_q.
  - Set rr_ptr=(g+1) mod NREQ. Go to DECODE.
  - If no req_valid, stay in IDLE.
- FSM DECODE (1 cycle):
  - ham_decoder sees code_q.
  - Register into the response registers:
    - rsp_pos = syndrome; rsp_err = (syndrome!=0).
    - corrected = code_q with bit (syndrome-1) inverted when syndrome!=0.
    - rsp_data = {corrected[6], corrected[5], corrected[4], corrected[2]}; rsp_id = id_q.
  - Increment err_count if rsp_err, saturating at all-ones.
  - Go to RESP.
- FSM RESP:
  - rsp_valid=1 and all rsp_* held stable until rsp_ready=1.
  - On rsp_valid&&rsp_ready go to IDLE with rsp_valid=0 next cycle.
  - No new grant in this state.
- Latency: grant edge N, rsp_valid high from edge N+2. Minimum 3 cycles per transaction when rsp_ready is tied high.
- Requester must hold req_valid and req_code until its req_ready pulse. Deasserting earlier just drops the request; no state is kept.
- Arbitration is fair: a continuously requesting index waits at most NREQ-1 other grants.
- clr_count:
  - Clears err_count next edge.
  - If it coincides with an increment, clear wins (result 0).
- Double-bit errors are not detected. A nonzero syndrome is always treated as a single error and "corrected".
- rst in any state returns to reset values on the next edge. An in-flight transaction is discarded with no response.

Optional Feature:
ERR_INJECT_EN:
- When defined, adds inputs inj_en (1) and inj_mask (7).
- In IDLE on grant, the latched code_q = req_code slice XOR (inj_en ? inj_mask : 0).
- Used for self-test of the decode path.
- When undefined, the ports are absent and code_q is the unmodified slice.

Test Plan:
- Reset, then req_valid=4'b0001 with codeword 7'b1010101 -> req_ready[0] pulse; 2 cycles later rsp_valid=1, rsp_data=4'b1011, rsp_err=0, rsp_pos=0, err_count=0.
- Requester 2 sends 7'b0010101 -> rsp_id=2, rsp_err=1, rsp_pos=7, rsp_data=4'b1011, err_count increments to 1.
- req_valid=4'b1111 held with rsp_ready=1 -> grant order 0,1,2,3,0; rr_ptr wraps; each response spaced 3 cycles.
- rsp_ready=0 for 5 cycles during RESP -> rsp_* stable, no req_ready pulses; releases on rsp_ready=1.
- Preload err_count to all-ones via repeated errored requests (CNT_W=2 build) -> stays 3; assert clr_count on an errored response cycle -> 0.
- Assert rst during DECODE -> next cycle rsp_valid=0 and all outputs at reset values; no response for the dropped request.
